// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a programmable bit-period divider.
// Define UART_TX_IRQ_EN to add the CTRL irq_en bit and the registered irq output.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
   parameter int unsigned DEPTH       = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        WE,
   input  logic        RE,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
`ifdef UART_TX_IRQ_EN
   output logic        irq,
`endif
   output logic        tx
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e        state_q, state_d;
   logic [7:0]    fifo_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q;
   logic [15:0]   div_q;
   logic [15:0]   cur_div_q, cur_div_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          pop, push, push_ok, bit_end;
   logic          sel, wr_data, wr_status, wr_div, busy, full, empty;
   logic          unused_bits;

   assign sel       = (A[31:4] == BASE_ADDR[31:4]);
   assign wr_data   = WE && sel && (A[3:2] == 2'd0);
   assign wr_status = WE && sel && (A[3:2] == 2'd1);
   assign wr_div    = WE && sel && (A[3:2] == 2'd2);
   assign busy      = (state_q != StIdle);
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign bit_end   = (cnt_q == cur_div_q - 16'd1);
   assign unused_bits = ^{A[1:0], WD[31:16]};

   // A full FIFO still accepts a push when the transmitter pops in the same cycle.
   assign push    = wr_data;
   assign push_ok = push && (!full || pop);

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= WD[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         div_q    <= DEFAULT_DIV;
      end else begin
         count_q <= count_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && full && !pop) ovf_q <= 1'b1;
         else if (wr_status)       ovf_q <= 1'b0;
         if (wr_div) div_q <= (WD[15:0] == 16'd0) ? 16'd1 : WD[15:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         cur_div_q <= 16'd1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         cur_div_q <= cur_div_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      cur_div_d = cur_div_q;
      pop       = 1'b0;
      case (state_q)
         StIdle: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = fifo_q[rd_ptr_q];
               cur_div_d = div_q;
               cnt_d     = '0;
               state_d   = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = StStop;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Decoded from state so reset forces the line idle without waiting for a clock.
   always_comb begin
      tx = 1'b1;
      case (state_q)
         StStart: tx = 1'b0;
         StData:  tx = shift_q[0];
         default: tx = 1'b1;
      endcase
   end

`ifdef UART_TX_IRQ_EN
   logic irq_en_q, irq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_q <= irq_en_q && empty && !busy;
         if (WE && sel && (A[3:2] == 2'd3)) irq_en_q <= WD[0];
      end
   end

   assign irq = irq_q;
`endif

   always_comb begin
      RD = '0;
      if (RE && sel) begin
         case (A[3:2])
            2'd1:    RD = {17'b0, 8'(count_q), 3'b0, ovf_q, empty, full, busy};
            2'd2:    RD = {16'b0, div_q};
`ifdef UART_TX_IRQ_EN
            2'd3:    RD = {31'b0, irq_en_q};
`endif
            default: RD = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random bus traffic, all checked every cycle
// against a frame-timeline model of the transmitter (expected tx derived from frame start time).
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE   = 32'h0000_0100;
   localparam int          DEPTH  = 4;
   localparam int          DEFDIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        WE, RE;
   logic [31:0] A, WD, RD;
   logic        tx;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH),
      .DEFAULT_DIV(16'(DEFDIV))
   ) dut (
      .clk(clk),
      .rst(rst),
      .WE (WE),
      .RE (RE),
      .A  (A),
      .WD (WD),
      .RD (RD),
`ifdef UART_TX_IRQ_EN
      .irq(irq),
`endif
      .tx (tx)
   );

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: queued bytes, plus the frame in flight described by its start edge, byte and period.
   logic [7:0] m_q[$];
   bit         m_busy;
   int         m_start;
   logic [7:0] m_byte;
   int         m_fdiv;
   bit         m_ovf;
   int         m_div;
   int         edge_n;
   bit         m_irq_en;
   bit         m_irq;

   task automatic model_reset();
      m_q.delete();
      m_busy   = 0;
      m_ovf    = 0;
      m_div    = DEFDIV;
      m_irq_en = 0;
      m_irq    = 0;
      m_fdiv   = 1;
   endtask

   task automatic model_edge();
      bit old_busy  = m_busy;
      int old_size  = m_q.size();
      int old_div   = m_div;
      bit old_irqen = m_irq_en;
      bit popped    = 0;
      edge_n++;
      if (m_busy && (edge_n - m_start == 10 * m_fdiv)) begin
         m_busy = 0;
      end else if (!old_busy && old_size > 0) begin
         popped  = 1;
         m_byte  = m_q.pop_front();
         m_busy  = 1;
         m_start = edge_n;
         m_fdiv  = old_div;
      end
      m_irq = old_irqen && (old_size == 0) && !old_busy;
      if (WE && (A[31:4] == BASE[31:4])) begin
         case (A[3:2])
            2'd0: if (old_size < DEPTH || popped) m_q.push_back(WD[7:0]); else m_ovf = 1;
            2'd1: m_ovf = 0;
            2'd2: m_div = (WD[15:0] == 16'd0) ? 1 : int'(WD[15:0]);
`ifdef UART_TX_IRQ_EN
            2'd3: m_irq_en = WD[0];
`endif
            default: ;
         endcase
      end
   endtask

   function automatic logic exp_tx();
      int off, b;
      if (!m_busy) return 1'b1;
      off = edge_n - m_start;
      b   = off / m_fdiv;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_byte[b-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_rd();
      logic [31:0] r = '0;
      if (!RE || (A[31:4] != BASE[31:4])) return '0;
      case (A[3:2])
         2'd1: begin
            r    = 32'(m_q.size()) << 7;
            r[3] = m_ovf;
            r[2] = (m_q.size() == 0);
            r[1] = (m_q.size() == DEPTH);
            r[0] = m_busy;
         end
         2'd2: r = 32'(m_div);
`ifdef UART_TX_IRQ_EN
         2'd3: r = {31'b0, m_irq_en};
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic cyc(input logic we_v, input logic re_v, input logic [31:0] a_v,
                      input logic [31:0] wd_v);
      WE = we_v; RE = re_v; A = a_v; WD = wd_v;
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
      check("tx", 32'(tx), 32'(exp_tx()));
      check("rd", RD, exp_rd());
`ifdef UART_TX_IRQ_EN
      check("irq", 32'(irq), 32'(m_irq));
`endif
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      cyc(1'b1, 1'b0, BASE + 32'(off), d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, BASE + 32'($urandom_range(0, 3) * 4), 32'h0);
   endtask

   // Combinational read between edges; the next cyc call re-drives the bus.
   task automatic peek(input string tag, input logic [3:0] off, input logic [31:0] exp);
      WE = 1'b0; RE = 1'b1; A = BASE + 32'(off);
      #1;
      check(tag, RD, exp);
   endtask

   initial begin
      rst = 1'b1; WE = 1'b0; RE = 1'b0; A = '0; WD = '0;
      edge_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      peek("reset_status", 4'h4, 32'h0000_0004);
      peek("reset_div", 4'h8, 32'h0000_0004);
      check("reset_tx", 32'(tx), 32'h1);

      // Single 0xA5 frame at the default period.
      wr(4'h0, 32'hA5);
      idle(45);
      peek("a5_done_status", 4'h4, 32'h0000_0004);

      // Six back-to-back pushes: the sixth overflows.
      for (int i = 1; i <= 5; i++) wr(4'h0, 32'(i));
      peek("five_status", 4'h4, 32'h0000_0203);
      wr(4'h0, 32'h06);
      peek("ovf_status", 4'h4, 32'h0000_020B);
      wr(4'h4, 32'h0);
      peek("ovf_clear", 4'h4, 32'h0000_0203);
      idle(5 * 41 + 10);

      // DIV of zero stores one; a mid-frame DIV change applies to the next frame.
      wr(4'h8, 32'h0);
      peek("div_zero", 4'h8, 32'h0000_0001);
      wr(4'h8, 32'h4);
      wr(4'h0, 32'h3C);
      idle(10);
      wr(4'h8, 32'h8);
      wr(4'h0, 32'hC3);
      idle(40 + 85);

      // Reset during data bit 3 with two bytes still queued.
      wr(4'h8, 32'h4);
      wr(4'h0, 32'h11);
      wr(4'h0, 32'h22);
      wr(4'h0, 32'h33);
      idle(14);
      check("pre_rst_tx", 32'(tx), 32'(exp_tx()));
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_tx", 32'(tx), 32'h1);
      peek("rst_status", 4'h4, 32'h0000_0004);
      peek("rst_div", 4'h8, 32'(DEFDIV));
      @(negedge clk);
      rst = 1'b0;
      idle(60);

      // Interrupt enable around a frame (CTRL is inert without the irq build).
      wr(4'hC, 32'h1);
      idle(3);
      wr(4'h0, 32'h5A);
      idle(45);
      wr(4'hC, 32'h0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic        we_r;
         logic [31:0] a_r, wd_r;
         we_r = ($urandom_range(0, 3) == 0);
         a_r  = BASE + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a_r = a_r + 32'h10 * 32'($urandom_range(1, 4));
         wd_r = $urandom;
         if (a_r[3:2] == 2'd2) wd_r = {$urandom, 16'($urandom_range(0, 5))};
         // Keep DIV/STATUS writes rarer so frames actually drain.
         if (we_r && a_r[3:2] != 2'd0 && $urandom_range(0, 3) != 0) we_r = 1'b0;
         cyc(we_r, 1'($urandom_range(0, 1)), a_r, wd_r);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
